// File: rtl/ysyx_23060059_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_23060059_ifu -- instruction fetch unit
//
// Holds the architectural fetch PC and issues one 32-bit read per instruction
// on an AXI-lite-style read channel. Only one fetch is ever in flight. The
// fetched word and its PC go to decode/execute over a valid/ready handshake.
// The next PC (sequential, branch, jump or trap target) comes back from execute.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous reset, active-low (0 = reset)
//   pc_in        next PC from execute
//   pc_in_valid  pc_in is valid (current instruction retired)
//   pc_in_ready  IFU accepts pc_in this cycle
//   araddr       fetch address (always the current fetch PC)
//   arvalid      fetch address valid
//   arready      memory accepts the address
//   rdata        fetched word
//   rresp        response code, 2'b00 = OKAY, anything else = error
//   rvalid       rdata/rresp valid
//   rready       IFU accepts read data
//   inst         instruction to decode
//   inst_pc      PC of inst
//   inst_valid   inst/inst_pc/fetch_err valid
//   inst_ready   decode/execute consumes inst
//   fetch_err    inst is a substituted ERR_INST (bus error or misaligned PC)
//
// Every handshake output is decoded from the state register alone, so there is
// no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module ysyx_23060059_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ERR_INST = 32'h0010_0073   // ebreak
) (
    input  logic        clk,
    input  logic        rst,

    // next PC from execute
    input  logic [31:0] pc_in,
    input  logic        pc_in_valid,
    output logic        pc_in_ready,

    // read address channel
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,

    // read data channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    // instruction to decode
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_RST = 3'd0,   // first cycle after reset release, nothing asserted
        S_AR  = 3'd1,   // presenting fetch address
        S_R   = 3'd2,   // waiting for read data
        S_OUT = 3'd3,   // presenting instruction to decode
        S_PC  = 3'd4    // waiting for the next PC from execute
    } state_t;

    state_t      state;
    logic [31:0] pc_r;

    // A next PC that is not word aligned never reaches the bus; it is turned
    // into an error instruction directly.
    logic pc_in_aligned;
    assign pc_in_aligned = (pc_in[1:0] == 2'b00);

    // NOTE: all state lives in this one clocked block and uses non-blocking
    // assignments, so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset wins over everything and abandons any fetch in flight.
            state     <= S_RST;
            pc_r      <= RESET_PC;
            inst      <= '0;
            inst_pc   <= RESET_PC;
            fetch_err <= 1'b0;
        end else begin
            unique case (state)
                S_RST: begin
                    state <= S_AR;
                end

                S_AR: begin
                    if (arready) begin
                        state <= S_R;
                    end
                end

                S_R: begin
                    if (rvalid) begin
                        inst_pc <= pc_r;
                        if (rresp == RESP_OKAY) begin
                            inst      <= rdata;
                            fetch_err <= 1'b0;
                        end else begin
                            inst      <= ERR_INST;
                            fetch_err <= 1'b1;
                        end
                        state <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (inst_ready) begin
                        state <= S_PC;
                    end
                end

                S_PC: begin
                    if (pc_in_valid) begin
                        pc_r <= pc_in;
                        if (pc_in_aligned) begin
                            state <= S_AR;
                        end else begin
                            inst      <= ERR_INST;
                            inst_pc   <= pc_in;
                            fetch_err <= 1'b1;
                            state     <= S_OUT;
                        end
                    end
                end

                default: begin
                    state <= S_RST;
                end
            endcase
        end
    end

    // Handshake outputs: pure state decode.
    assign arvalid     = (state == S_AR);
    assign rready      = (state == S_R);
    assign inst_valid  = (state == S_OUT);
    assign pc_in_ready = (state == S_PC);
    assign araddr      = pc_r;

endmodule
